inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Writer side of the instruction memory. Receives a framed byte stream (host/UART/bench) and writes instruction words into the instruction store as a write port: WrEn, WrAddr, WrData.
- Validates frame length, reserved bits and checksum; reports Done or Error.
- Sits beside the instruction memory and is used only before the core is released from reset or halt.

Parameters:
- A, 10, instruction address width; memory depth 2**A words.
- W, 9, instruction word width; legal range 9..16.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  begin a new frame; honoured only in IDLE, DONE or ERR.
- ByteIn  input  8  stream data byte.
- ByteValid  input  1  ByteIn is valid.
- ByteReady  output  1  loader accepts a byte. A transfer occurs on a Clk edge where ByteValid && ByteReady.
- WrEn  output  1  one-cycle write strobe to instruction memory.
- WrAddr  output  A  write address.
- WrData  output  W  write data.
- Busy  output  1  frame in progress.
- Done  output  1  frame loaded and checksum good; sticky until Start.
- Error  output  1  frame rejected; sticky until Start.
- WordCount  output  A+1  words written in the current frame.

Behaviour:
- Reset (async, Reset==0): state IDLE; every output 0, including ByteReady, WrEn, WrAddr, WrData, Busy, Done, Error and WordCount.
  - Reset mid-frame aborts the frame immediately. No further WrEn is issued. Words already written stay in memory.
- Frame format, in order:
  - CNT_LO, CNT_HI: 16-bit word count N, little-endian.
  - N words of 2 bytes each: low byte = WrData[7:0]; high byte bits [W-9:0] = WrData[W-1:8]; high byte bits [7:W-8] are reserved and must be 0.
  - CHK: XOR of all preceding bytes in the frame, header included.
- States: IDLE, HDR_LO, HDR_HI, DAT_LO, DAT_HI, CHECK, DONE, ERR.
  - IDLE/DONE/ERR + Start: go to HDR_LO. Clear Done, Error, WordCount, the running checksum and the address counter.
  - HDR_LO --byte--> HDR_HI --byte--> DAT_LO if 1 <= N <= 2**A; otherwise ERR.
  - DAT_LO --byte--> DAT_HI.
  - DAT_HI --byte--> if reserved bits are nonzero: ERR, and no write for that word. Otherwise write the word, then go to DAT_LO if more words remain, else CHECK.
  - CHECK --byte--> DONE if the running XOR equals the byte; otherwise ERR.
- ByteReady = 1 exactly in HDR_LO, HDR_HI, DAT_LO, DAT_HI and CHECK. It is registered and may stay high continuously, giving one byte per cycle with back-to-back transfers.
- Busy = 1 in the same states as ByteReady.
- Start while Busy is ignored.
- Write timing:
  - WrEn is high for exactly one cycle: the cycle after the accepting DAT_HI edge.
  - WrAddr/WrData are registered and stable during that cycle. WrAddr and WrData hold their last values afterwards.
  - Addresses run 0..N-1 with no wrap. N = 2**A ends exactly at address 2**A-1.
  - WordCount increments on the same edge that raises WrEn.
- Done and Error rise on the edge that accepts the deciding byte and are mutually exclusive.
- ByteValid gaps stall the FSM with no state change. ByteIn is sampled only on transfer edges.
- Checksum is computed over accepted bytes only.
- Bytes offered after DONE/ERR are not accepted (ByteReady = 0).

Test Plan:
- Basic load:
  - Stimulus: Start, then bytes 03 00 AB 00 FF 01 00 01 57 back-to-back.
  - Response: WrEn pulses at (0,0x0AB), (1,0x1FF), (2,0x100). Done=1, Error=0, WordCount=3, Busy=0, ByteReady=0.
- Bad checksum:
  - Stimulus: same stream with last byte 58.
  - Response: same three writes; Error=1, Done=0. A new Start clears Error and WordCount to 0.
- Bad header:
  - Stimulus: Start, bytes 00 00. Response: Error=1 after the 2nd byte, no WrEn, ByteReady=0.
  - Stimulus: bytes 01 04 (N=1025). Response: same result.
- Reserved bits:
  - Stimulus: Start, bytes 01 00 12 02.
  - Response: Error=1, no WrEn ever, WordCount=0.
- Flow control:
  - Stimulus: stream from the basic load with ByteValid toggling 1-0-0-1, plus a Start pulse mid-frame.
  - Response: results identical to the basic load; the mid-frame Start is ignored.
- Reset mid-frame:
  - Stimulus: drop Reset after the 2nd WrEn of the basic load.
  - Response: all outputs 0 asynchronously, no 3rd write. Start plus a full frame after release loads correctly from address 0.

Source files
------------

// File: rtl/inst_loader.sv
// Instruction-memory loader: parses a framed byte stream (count header,
// N two-byte words, XOR checksum) and drives the instruction store's write
// port. Reports Done or Error, both sticky until the next Start.
module inst_loader #(
    parameter int unsigned A = 10,
    parameter int unsigned W = 9
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [7:0]   ByteIn,
    input  logic         ByteValid,
    output logic         ByteReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         Busy,
    output logic         Done,
    output logic         Error,
    output logic [A:0]   WordCount
);

    // High-byte bits above the word's top bit are reserved (none when W == 16).
    localparam logic [7:0]  RSV_MASK = 8'(16'h00FF << (W - 8));
    localparam logic [16:0] DEPTH    = 17'(2 ** A);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  lo_q;
    logic [A:0]  n_q;
    logic [7:0]  chk_q;

    logic        xfer;
    logic        start_go;
    logic        busy_next;
    logic [15:0] hdr_n;
    logic        hdr_ok;
    logic        rsv_bad;
    logic [A:0]  wc_inc;
    logic        last_word;
    logic        wr_fire;

    assign xfer      = ByteValid && ByteReady;
    assign start_go  = Start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign hdr_n     = {ByteIn, lo_q};
    assign hdr_ok    = (hdr_n != 16'd0) && ({1'b0, hdr_n} <= DEPTH);
    assign rsv_bad   = |(ByteIn & RSV_MASK);
    assign wc_inc    = WordCount + (A+1)'(1);
    assign last_word = (wc_inc == n_q);
    assign wr_fire   = (state == S_DAT_HI) && xfer && !rsv_bad;

    // Next-state decode; every transition outside IDLE/DONE/ERR needs a transfer.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (Start) next_state = S_HDR_LO;
            S_HDR_LO: if (xfer) next_state = S_HDR_HI;
            S_HDR_HI: if (xfer) next_state = hdr_ok ? S_DAT_LO : S_ERR;
            S_DAT_LO: if (xfer) next_state = S_DAT_HI;
            S_DAT_HI: begin
                if (xfer) begin
                    if (rsv_bad)        next_state = S_ERR;
                    else if (last_word) next_state = S_CHECK;
                    else                next_state = S_DAT_LO;
                end
            end
            S_CHECK: if (xfer) next_state = (chk_q == ByteIn) ? S_DONE : S_ERR;
            default: next_state = S_IDLE;
        endcase
    end

    assign busy_next = (next_state == S_HDR_LO) || (next_state == S_HDR_HI) ||
                       (next_state == S_DAT_LO) || (next_state == S_DAT_HI) ||
                       (next_state == S_CHECK);

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Registered status/handshake outputs (decoded from the next state so they
    // line up with the state they describe), plus the frame datapath.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ByteReady <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
            WrEn      <= 1'b0;
            WrAddr    <= '0;
            WrData    <= '0;
            WordCount <= '0;
            lo_q      <= '0;
            n_q       <= '0;
            chk_q     <= '0;
        end else begin
            ByteReady <= busy_next;
            Busy      <= busy_next;
            Done      <= (next_state == S_DONE);
            Error     <= (next_state == S_ERR);
            WrEn      <= wr_fire;
            if (start_go) begin
                WordCount <= '0;
                chk_q     <= '0;
            end else if (xfer) begin
                if (state != S_CHECK)                        chk_q <= chk_q ^ ByteIn;
                if (state == S_HDR_LO || state == S_DAT_LO)  lo_q  <= ByteIn;
                if (state == S_HDR_HI)                       n_q   <= (A+1)'(hdr_n);
                // WordCount doubles as the address counter: it equals the
                // index of the word being written.
                if (wr_fire) begin
                    WrAddr    <= WordCount[A-1:0];
                    WrData    <= W'({ByteIn, lo_q});
                    WordCount <= wc_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: table-driven frames, flow-control and
// reset corner sequences, and random frames against a frame-parsing model.
module tb_inst_loader;

    localparam int A     = 10;
    localparam int W     = 9;
    localparam int DEPTH = 1 << A;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [7:0]   ByteIn;
    logic         ByteValid;
    logic         ByteReady;
    logic         WrEn;
    logic [A-1:0] WrAddr;
    logic [W-1:0] WrData;
    logic         Busy;
    logic         Done;
    logic         Error;
    logic [A:0]   WordCount;

    inst_loader #(.A(A), .W(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .WordCount (WordCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int              len;
        logic [0:15][7:0] b;
        logic            ed;
        logic            ee;
        int              ewc;
    } vec_t;

    vec_t tv [7];

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] frame [4096];
    int         frame_len;

    // Model results
    int   exp_q [$];
    logic exp_done;
    logic exp_err;
    int   exp_wc;
    int   consumed;

    // Observed writes
    int   got_q [$];

    always @(posedge Clk) begin
        #1;
        if (WrEn) got_q.push_back(int'(WrAddr) * 65536 + int'(WrData));
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Parse the frame byte by byte as the protocol describes it.
    function automatic void model();
        int         n;
        logic [7:0] x;
        logic [7:0] lo;
        logic [7:0] hi;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_wc   = 0;
        n        = int'(frame[1]) * 256 + int'(frame[0]);
        consumed = 2;
        if (n == 0 || n > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        x = frame[0] ^ frame[1];
        for (int i = 0; i < n; i++) begin
            lo = frame[2 + 2*i];
            hi = frame[3 + 2*i];
            consumed += 2;
            x = x ^ lo ^ hi;
            if ((int'(hi) >> (W - 8)) != 0) begin
                exp_err = 1'b1;
                return;
            end
            exp_q.push_back(i * 65536 + ((int'(hi) * 256 + int'(lo)) % (1 << W)));
            exp_wc++;
        end
        consumed++;
        if (frame[2 + 2*n] == x) exp_done = 1'b1;
        else                     exp_err  = 1'b1;
    endfunction

    task automatic do_start();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 valid pattern 1-0-0-1, 2 random gaps.
    task automatic send_byte(input logic [7:0] b, input int gap_mode, input bit pulse_start, input int idx);
        int gaps;
        bit ok;
        gaps = 0;
        ok   = 1'b0;
        if (gap_mode == 1)      gaps = (idx % 2 == 1) ? 2 : 0;
        else if (gap_mode == 2) gaps = $urandom_range(0, 2);
        if (pulse_start && gaps == 0) gaps = 1;
        for (int g = 0; g < gaps; g++) begin
            @(negedge Clk);
            ByteValid = 1'b0;
            ByteIn    = 8'($urandom);
            Start     = pulse_start;
        end
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge Clk);
            Start     = 1'b0;
            ByteValid = 1'b1;
            ByteIn    = b;
            if (ByteReady) begin
                ok = 1'b1;
                @(posedge Clk);
            end
        end
        if (!ok) check($sformatf("byte%0d_ready", idx), ByteReady, 1'b1);
    endtask

    task automatic run_frame(input string tag, input int gap_mode, input bit mid_start);
        int nw;
        model();
        got_q.delete();
        do_start();
        check({tag, "_start_busy"}, Busy, 1'b1);
        check({tag, "_start_flags"}, {Done, Error}, 2'b00);
        check({tag, "_start_wc"}, WordCount, 0);
        for (int i = 0; i < consumed; i++)
            send_byte(frame[i], gap_mode, mid_start && (i == 4), i);
        @(negedge Clk);
        ByteValid = 1'b0;
        @(negedge Clk);
        check({tag, "_done"}, Done, exp_done);
        check({tag, "_error"}, Error, exp_err);
        check({tag, "_wc"}, WordCount, exp_wc);
        check({tag, "_idle"}, {Busy, ByteReady}, 2'b00);
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
        // A byte offered after the frame ends must be left alone.
        nw        = got_q.size();
        ByteValid = 1'b1;
        ByteIn    = 8'h5A;
        check({tag, "_post_ready"}, ByteReady, 1'b0);
        @(negedge Clk);
        ByteValid = 1'b0;
        check({tag, "_post_flags"}, {Done, Error}, {exp_done, exp_err});
        check({tag, "_post_nwrites"}, got_q.size(), nw);
    endtask

    task automatic load_vec(input int i);
        frame_len = tv[i].len;
        for (int j = 0; j < tv[i].len; j++) frame[j] = tv[i].b[j];
    endtask

    task automatic gen_random();
        int         n;
        int         kind;
        logic [7:0] x;
        logic [7:0] lo;
        logic [7:0] hi;
        kind = $urandom_range(0, 9);
        if (kind == 0)      n = 0;
        else if (kind == 1) n = 1025 + $urandom_range(0, 3000);
        else                n = $urandom_range(1, 12);
        frame[0]  = n[7:0];
        frame[1]  = n[15:8];
        frame_len = 2;
        if (n == 0 || n > DEPTH) return;
        x = frame[0] ^ frame[1];
        for (int i = 0; i < n; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom_range(0, (1 << (W - 8)) - 1));
            if ($urandom_range(0, 39) == 0) hi = hi | 8'h40;
            frame[2 + 2*i] = lo;
            frame[3 + 2*i] = hi;
            x = x ^ lo ^ hi;
        end
        frame[2 + 2*n] = x ^ (($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00);
        frame_len = 3 + 2*n;
    endtask

    initial begin
        tv[0] = '{9, {8'h03, 8'h00, 8'hAB, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h01, 8'h57, 56'h0}, 1'b1, 1'b0, 3};
        tv[1] = '{9, {8'h03, 8'h00, 8'hAB, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h01, 8'h58, 56'h0}, 1'b0, 1'b1, 3};
        tv[2] = '{2, {8'h00, 8'h00, 112'h0}, 1'b0, 1'b1, 0};
        tv[3] = '{2, {8'h01, 8'h04, 112'h0}, 1'b0, 1'b1, 0};
        tv[4] = '{4, {8'h01, 8'h00, 8'h12, 8'h02, 96'h0}, 1'b0, 1'b1, 0};
        tv[5] = '{5, {8'h01, 8'h00, 8'h34, 8'h01, 8'h34, 88'h0}, 1'b1, 1'b0, 1};
        tv[6] = '{6, {8'h02, 8'h00, 8'h11, 8'h00, 8'h22, 8'h80, 80'h0}, 1'b0, 1'b1, 1};

        Reset     = 1'b0;
        Start     = 1'b0;
        ByteIn    = 8'h00;
        ByteValid = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_state", {ByteReady, WrEn, WrAddr, WrData, Busy, Done, Error, WordCount}, '0);
        Reset = 1'b1;
        @(negedge Clk);

        // Table frames, each checked against its fixed result and the model
        for (int i = 0; i < 7; i++) begin
            load_vec(i);
            run_frame($sformatf("vec%0d", i), 0, 1'b0);
            check($sformatf("vec%0d_tbl_done", i), Done, tv[i].ed);
            check($sformatf("vec%0d_tbl_err", i), Error, tv[i].ee);
            check($sformatf("vec%0d_tbl_wc", i), WordCount, tv[i].ewc);
        end

        // Flow control with a Start pulse mid-frame
        load_vec(0);
        run_frame("flow", 1, 1'b1);
        check("flow_tbl_done", Done, 1'b1);
        check("flow_tbl_wc", WordCount, 3);

        // Random frames with random valid gaps
        for (int r = 0; r < 30; r++) begin
            gen_random();
            run_frame($sformatf("rand%0d", r), 2, 1'b0);
        end

        // Largest legal frame: last write lands on address 2**A-1
        begin
            logic [7:0] x;
            frame[0] = 8'(DEPTH & 255);
            frame[1] = 8'(DEPTH >> 8);
            x = frame[0] ^ frame[1];
            for (int i = 0; i < DEPTH; i++) begin
                frame[2 + 2*i] = 8'($urandom);
                frame[3 + 2*i] = 8'($urandom_range(0, 1));
                x = x ^ frame[2 + 2*i] ^ frame[3 + 2*i];
            end
            frame[2 + 2*DEPTH] = x;
            frame_len = 3 + 2*DEPTH;
            run_frame("nmax", 0, 1'b0);
            check("nmax_last_addr", WrAddr, DEPTH - 1);
        end

        // Reset after the second write of the basic frame
        load_vec(0);
        got_q.delete();
        do_start();
        for (int i = 0; i < 6; i++) send_byte(frame[i], 0, 1'b0, i);
        @(negedge Clk);
        check("rst_pre_writes", got_q.size(), 2);
        check("rst_pre_busy", Busy, 1'b1);
        ByteIn = 8'h00;
        #1 Reset = 1'b0;
        #1;
        check("rst_async_outputs", {ByteReady, WrEn, WrAddr, WrData, Busy, Done, Error, WordCount}, '0);
        repeat (3) @(posedge Clk);
        #2;
        check("rst_held_outputs", {ByteReady, WrEn, WrAddr, WrData, Busy, Done, Error, WordCount}, '0);
        check("rst_no_third_write", got_q.size(), 2);
        @(negedge Clk);
        ByteValid = 1'b0;
        Reset     = 1'b1;
        run_frame("post_reset", 0, 1'b0);
        check("post_reset_tbl_wc", WordCount, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
